textbuf_wb_slave: RTL and testbench



---
 rtl/textbuf_pkg.sv | 34 +++
 rtl/if_wb.sv | 41 ++++
 rtl/textbuf_ram.sv | 46 ++++
 rtl/textbuf_wb_slave.sv | 146 ++++++++++++++
 tb/tb_textbuf_wb_slave.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/textbuf_pkg.sv
// Shared types and constants for the 80x25 text-mode character buffer.
// Each 16-bit cell is {attribute, glyph}; two cells per 32-bit word.
package textbuf_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } fill_state_t;

    localparam int TEXT_COLS      = 80;
    localparam int TEXT_ROWS      = 25;
    localparam int WORDS_PER_LINE = 40;

    localparam int CELL_ATTR_MSB  = 15;
    localparam int CELL_ATTR_LSB  = 8;
    localparam int ATTR_R_MSB     = 7;
    localparam int ATTR_R_LSB     = 6;
    localparam int ATTR_G_MSB     = 5;
    localparam int ATTR_G_LSB     = 3;
    localparam int ATTR_B_MSB     = 2;
    localparam int ATTR_B_LSB     = 0;
    localparam int GLYPH_MSB      = 6;
    localparam int GLYPH_LSB      = 0;

    function automatic logic [15:0] text_cell(
        input logic [1:0] r,
        input logic [2:0] g,
        input logic [2:0] b,
        input logic [6:0] glyph
    );
        text_cell = {r, g, b, 1'b0, glyph};
    endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle between one master and one slave.
// Data signal names depend on whether modport expressions are usable.
interface if_wb;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic        ack;
    logic        stall;

`ifdef NO_MODPORT_EXPRESSIONS
    logic [31:0] dat_m;
    logic [31:0] dat_s;

    modport slave (
        input  cyc, stb, we, sel, adr, dat_m,
        output ack, stall, dat_s
    );

    modport master (
        output cyc, stb, we, sel, adr, dat_m,
        input  ack, stall, dat_s
    );
`else
    logic [31:0] dat_i;
    logic [31:0] dat_o;

    modport slave (
        input  cyc, stb, we, sel, adr, dat_i,
        output ack, stall, dat_o
    );

    modport master (
        output cyc, stb, we, sel, adr, dat_i,
        input  ack, stall, dat_o
    );
`endif

endinterface

// File: rtl/textbuf_ram.sv
// Single-port synchronous RAM with byte enables and write-first read data.
// Read data only updates on a read strobe so idle cycles leave it intact.
module textbuf_ram #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic                  rd,
    input  logic [DWIDTH/8-1:0]   we,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH-1:0]     rdata
);

    localparam int NB = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [0:2**AWIDTH-1];
    logic [DWIDTH-1:0] merged;

    always_comb begin
        merged = mem[addr];
        for (int k = 0; k < NB; k++) begin
            if (we[k]) begin
                merged[k*8 +: 8] = wdata[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en && (|we)) begin
            mem[addr] <= merged;
        end
    end

    // The merged word is what a same-cycle read must see.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (en && rd) begin
            rdata <= merged;
        end
    end

endmodule

// File: rtl/textbuf_wb_slave.sv
// Wishbone pipelined slave holding the text buffer, with a background
// fill engine that steals RAM cycles whenever the bus is idle.
module textbuf_wb_slave
    import textbuf_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter bit OUTREG = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] fill_i,
    output logic        busy_o,
    if_wb.slave         bus
);

    localparam int LAT = OUTREG ? 2 : 1;

    logic              req;
    logic [AWIDTH-1:0] widx;
    logic [31:0]       wdat;
    logic [31:0]       dout;

    fill_state_t       state;
    logic [AWIDTH-1:0] ptr;
    logic [31:0]       fill_q;
    logic              fill_wr;

    logic              ram_en;
    logic              ram_rd;
    logic [3:0]        ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [1:0]        vld;
    logic              unused_adr;

`ifdef NO_MODPORT_EXPRESSIONS
    assign wdat      = bus.dat_m;
    assign bus.dat_s = dout;
`else
    assign wdat      = bus.dat_i;
    assign bus.dat_o = dout;
`endif

    assign bus.stall  = 1'b0;
    assign req        = bus.cyc && bus.stb;
    assign widx       = bus.adr[AWIDTH+1:2];
    assign unused_adr = ^{bus.adr[31:AWIDTH+2], bus.adr[1:0]};

    // A clear_i cycle restarts the fill, so it never writes stale data.
    assign fill_wr = (state == S_CLEAR) && !req && !clear_i;
    assign busy_o  = (state == S_CLEAR);

    always_comb begin
        ram_en    = req || fill_wr;
        ram_rd    = req;
        ram_we    = 4'h0;
        ram_addr  = ptr;
        ram_wdata = fill_q;
        if (req) begin
            ram_addr  = widx;
            ram_wdata = wdat;
            if (bus.we) begin
                ram_we = bus.sel;
            end
        end else if (fill_wr) begin
            ram_we = 4'hF;
        end
    end

    textbuf_ram #(
        .AWIDTH (AWIDTH),
        .DWIDTH (32)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ram_en),
        .rd    (ram_rd),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            ptr    <= '0;
            fill_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (clear_i) begin
                        fill_q <= fill_i;
                        ptr    <= '0;
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clear_i) begin
                        fill_q <= fill_i;
                        ptr    <= '0;
                    end else if (fill_wr) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == {AWIDTH{1'b1}}) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Dropping cyc discards every in-flight ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld <= 2'b00;
        end else if (!bus.cyc) begin
            vld <= 2'b00;
        end else begin
            vld <= {vld[0], req};
        end
    end

    assign bus.ack = vld[LAT-1] && bus.cyc;

    if (OUTREG) begin : g_oreg
        logic [31:0] dat_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dat_q <= '0;
            end else if (vld[0] && bus.cyc) begin
                dat_q <= ram_rdata;
            end
        end

        assign dout = dat_q;
    end else begin : g_comb
        assign dout = ram_rdata;
    end

endmodule

// File: tb/tb_textbuf_wb_slave.sv
// Directed self-checking bench for textbuf_wb_slave (OUTREG=1, AWIDTH=10).
module tb_textbuf_wb_slave;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] fill;
    logic        busy;
    logic [31:0] wdat;
    logic [31:0] rdat;

    int n_tests = 0;
    int n_fail  = 0;

    if_wb bus();

`ifdef NO_MODPORT_EXPRESSIONS
    assign bus.dat_m = wdat;
    assign rdat      = bus.dat_s;
`else
    assign bus.dat_i = wdat;
    assign rdat      = bus.dat_o;
`endif

    textbuf_wb_slave #(
        .AWIDTH (10),
        .OUTREG (1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .fill_i  (fill),
        .busy_o  (busy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        bus.sel = 4'h0;
    endtask

    function automatic logic [31:0] pre(input int i);
        pre = {i[15:0], i[15:0]};
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        n = 0;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b1;
        bus.sel = s;
        bus.adr = a;
        wdat    = d;
        step();
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        while (!bus.ack && n < 10) begin
            step();
            n++;
        end
        if (!bus.ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_timeout adr=%h ack=%b required 1", a, bus.ack);
        end
        idle();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.sel = 4'hF;
        bus.adr = a;
        lat = 1;
        step();
        bus.stb = 1'b0;
        while (!bus.ack && lat < 10) begin
            step();
            lat++;
        end
        if (!bus.ack) lat = -1;
        d = rdat;
        idle();
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack got=%b want=0", bus.ack);
        end
        n_tests++;
        if (rdat !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_dat got=%h want=0", rdat);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_line_fetch();
        int first;
        int last;
        int cnt;
        int bad;
        first = -1;
        last  = -1;
        cnt   = 0;
        bad   = 0;
        for (int i = 0; i < 40; i++) wb_write(i * 4, pre(i), 4'hF);
        step();
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = 32'h0;
        for (int i = 1; i <= 46; i++) begin
            step();
            if (bus.ack === 1'b1) begin
                if (rdat !== pre(cnt)) begin
                    bad++;
                    $display("FAIL burst_data beat=%0d got=%h want=%h",
                             cnt, rdat, pre(cnt));
                end
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            if (i < 40) bus.adr = i * 4;
            else bus.stb = 1'b0;
        end
        idle();
        n_tests++;
        if (bad != 0) n_fail++;
        n_tests++;
        if (first != 2) begin
            n_fail++;
            $display("FAIL burst_first_ack got=%0d want=2", first);
        end
        n_tests++;
        if (cnt != 40) begin
            n_fail++;
            $display("FAIL burst_ack_count got=%0d want=40", cnt);
        end
        n_tests++;
        if (last - first + 1 != 40) begin
            n_fail++;
            $display("FAIL burst_gapless span=%0d want=40", last - first + 1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        int lat;
        wb_write(32'd20, 32'hAABBCCDD, 4'hF);
        wb_write(32'd20, 32'h11223344, 4'b0101);
        wb_read(32'd20, d, lat);
        n_tests++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL lanes_latency got=%0d want=2", lat);
        end
        n_tests++;
        if (d !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL lanes_data got=%h want=aa22cc44", d);
        end
    endtask

    task automatic test_back_to_back();
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b1;
        bus.sel = 4'hF;
        bus.adr = 32'd36;
        wdat    = 32'hDEADBEEF;
        step();
        bus.we = 1'b0;
        step();
        bus.stb = 1'b0;
        n_tests++;
        if (bus.ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_write_ack got=%b want=1", bus.ack);
        end
        step();
        n_tests++;
        if (bus.ack !== 1'b1 || rdat !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL b2b_read ack=%b dat=%h want ack=1 dat=deadbeef",
                     bus.ack, rdat);
        end
        step();
        n_tests++;
        if (bus.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail_ack got=%b want=0", bus.ack);
        end
        idle();
        step();
    endtask

    task automatic test_cyc_drop();
        int cnt;
        int late;
        int bad;
        logic [31:0] d;
        logic [31:0] e;
        int lat;
        cnt  = 0;
        late = 0;
        bad  = 0;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = 32'h0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (bus.ack === 1'b1) begin
                e = (cnt == 5) ? 32'hAA22CC44 : pre(cnt);
                if (rdat !== e) begin
                    bad++;
                    $display("FAIL drop_data beat=%0d got=%h want=%h",
                             cnt, rdat, e);
                end
                cnt++;
                if (i > 10) late++;
            end
            if (i < 10) bus.adr = i * 4;
            if (i == 10) begin
                bus.cyc = 1'b0;
                bus.stb = 1'b0;
            end
            if (i == 13) bus.cyc = 1'b1;
        end
        idle();
        n_tests++;
        if (bad != 0) n_fail++;
        n_tests++;
        if (cnt != 9) begin
            n_fail++;
            $display("FAIL drop_ack_count got=%0d want=9", cnt);
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL drop_late_acks got=%0d want=0", late);
        end
        wb_read(32'd28, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h00070007) begin
            n_fail++;
            $display("FAIL drop_next lat=%0d dat=%h want 2 00070007", lat, d);
        end
    endtask

    task automatic test_fill_idle();
        int cnt;
        int n;
        logic [31:0] d;
        int lat;
        cnt = 0;
        n   = 0;
        fill  = 32'h07200720;
        clear = 1'b1;
        step();
        clear = 1'b0;
        fill  = 32'hFFFFFFFF;
        while (busy === 1'b1 && n < 3000) begin
            cnt++;
            step();
            n++;
        end
        n_tests++;
        if (cnt != 1024) begin
            n_fail++;
            $display("FAIL fill_busy_cycles got=%0d want=1024", cnt);
        end
        wb_read(32'd0, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h07200720) begin
            n_fail++;
            $display("FAIL fill_w0 lat=%0d dat=%h want 2 07200720", lat, d);
        end
        wb_read(32'd511 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h07200720) begin
            n_fail++;
            $display("FAIL fill_w511 lat=%0d dat=%h want 2 07200720", lat, d);
        end
        wb_read(32'd1023 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h07200720) begin
            n_fail++;
            $display("FAIL fill_w1023 lat=%0d dat=%h want 2 07200720", lat, d);
        end
    endtask

    task automatic test_fill_traffic();
        bit hist [0:2100];
        bit s;
        bit e;
        int bcnt;
        int bad;
        logic [31:0] d;
        int lat;
        bcnt = 0;
        bad  = 0;
        hist[0] = 1'b0;
        fill  = 32'h0F410F41;
        clear = 1'b1;
        bus.cyc = 1'b1;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        for (int i = 1; i <= 2070; i++) begin
            step();
            clear = 1'b0;
            if (busy === 1'b1) bcnt++;
            e = (i >= 2) ? hist[i-2] : 1'b0;
            if (bus.ack !== e) bad++;
            s = (i % 2 == 1) && (i < 2060);
            bus.stb = s;
            bus.adr = ((i * 7) % 1024) * 4;
            hist[i] = s;
        end
        idle();
        step();
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL traffic_ack_timing errors=%0d want=0", bad);
        end
        n_tests++;
        if (bcnt < 2047 || bcnt > 2049) begin
            n_fail++;
            $display("FAIL traffic_busy_cycles got=%0d want=2048", bcnt);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL traffic_done busy=%b want=0", busy);
        end
        wb_read(32'd1023 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h0F410F41) begin
            n_fail++;
            $display("FAIL traffic_w1023 lat=%0d dat=%h want 2 0f410f41", lat, d);
        end
        wb_read(32'd777 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h0F410F41) begin
            n_fail++;
            $display("FAIL traffic_w777 lat=%0d dat=%h want 2 0f410f41", lat, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        bus.adr = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            step();
            bus.adr = i * 4;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_burst_ack got=%b want=0", bus.ack);
        end
        n_tests++;
        if (rdat !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_burst_dat got=%h want=0", rdat);
        end
        idle();
        step();
        rst = 1'b0;
        step();
        fill  = 32'h12345678;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill_busy got=%b want=0", busy);
        end
        step();
        rst = 1'b0;
        step();
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill_resumed busy=%b want=0", busy);
        end
        wb_read(32'd300 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h0F410F41) begin
            n_fail++;
            $display("FAIL rst_read_w300 lat=%0d dat=%h want 2 0f410f41", lat, d);
        end
        wb_read(32'd10 * 4, d, lat);
        n_tests++;
        if (lat != 2 || d !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rst_read_w10 lat=%0d dat=%h want 2 12345678", lat, d);
        end
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        fill    = 32'h0;
        wdat    = 32'h0;
        bus.adr = 32'h0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        test_reset();
        test_line_fetch();
        test_byte_lanes();
        test_back_to_back();
        test_cyc_drop();
        test_fill_idle();
        test_fill_traffic();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
